// File: rtl/alu_issue_pkg.sv
// Shared definitions for the ALU issue stage: ALU op encoding, RV64I opcodes,
// funct7 values and the issue bundle handed from decode to the pipeline register.
package alu_issue_pkg;

  localparam int XLEN = 64;

  localparam logic [3:0] ALU_DIRECT = 4'b0000;
  localparam logic [3:0] ALU_ADD    = 4'b0001;
  localparam logic [3:0] ALU_SUB    = 4'b0010;
  localparam logic [3:0] ALU_AND    = 4'b0011;
  localparam logic [3:0] ALU_OR     = 4'b0100;
  localparam logic [3:0] ALU_XOR    = 4'b0101;
  localparam logic [3:0] ALU_SLL    = 4'b0110;
  localparam logic [3:0] ALU_SRL    = 4'b0111;
  localparam logic [3:0] ALU_SRA    = 4'b1000;
  localparam logic [3:0] ALU_SLT    = 4'b1001;
  localparam logic [3:0] ALU_SLTU   = 4'b1010;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
  localparam logic [6:0] OPC_OP32     = 7'b0111011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    logic [3:0]      alu_op;
    logic [XLEN-1:0] src1;
    logic [XLEN-1:0] src2;
    logic            word;
    logic [4:0]      rd;
    logic            rd_wen;
    logic [XLEN-1:0] pc;
    logic            illegal;
  } issue_bundle_t;

endpackage

// File: rtl/alu_issue_if.sv
// Handshake and bundle signals between register-read, the issue stage and the ALU.
// The issue stage uses the slave view; the surrounding pipeline drives the master view.
interface alu_issue_if;
  import alu_issue_pkg::*;

  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_inst;
  logic [XLEN-1:0] in_pc;
  logic [XLEN-1:0] in_rs1_data;
  logic [XLEN-1:0] in_rs2_data;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [3:0]      out_alu_op;
  logic [XLEN-1:0] out_src1;
  logic [XLEN-1:0] out_src2;
  logic            out_word;
  logic [4:0]      out_rd;
  logic            out_rd_wen;
  logic [XLEN-1:0] out_pc;
  logic            out_illegal;

  modport slave (
    input  in_valid, in_inst, in_pc, in_rs1_data, in_rs2_data, flush, out_ready,
    output in_ready, out_valid, out_alu_op, out_src1, out_src2, out_word,
           out_rd, out_rd_wen, out_pc, out_illegal
  );

  modport master (
    output in_valid, in_inst, in_pc, in_rs1_data, in_rs2_data, flush, out_ready,
    input  in_ready, out_valid, out_alu_op, out_src1, out_src2, out_word,
           out_rd, out_rd_wen, out_pc, out_illegal
  );

endinterface

// File: rtl/alu_issue_dec.sv
// Combinational decoder: turns one RV64I integer-compute instruction plus its
// register values into an ALU bundle, including shift masking and W-variant
// operand conditioning. Unsupported encodings come out as an inert illegal bundle.
module alu_issue_dec
  import alu_issue_pkg::*;
(
  input  logic [31:0]     inst,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output issue_bundle_t   bundle
);

  logic [6:0]      opcode;
  logic [6:0]      funct7;
  logic [2:0]      funct3;
  logic [4:0]      rd;
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_u;
  logic [XLEN-1:0] rs1_sext32;
  logic [XLEN-1:0] rs1_zext32;
  logic [XLEN-1:0] shamt6_imm;
  logic [XLEN-1:0] shamt5_imm;
  logic [XLEN-1:0] shamt6_reg;
  logic [XLEN-1:0] shamt5_reg;

  logic            legal;
  logic [3:0]      alu_op;
  logic [XLEN-1:0] src1;
  logic [XLEN-1:0] src2;
  logic            word;

  assign opcode     = inst[6:0];
  assign funct3     = inst[14:12];
  assign funct7     = inst[31:25];
  assign rd         = inst[11:7];
  assign imm_i      = {{(XLEN-12){inst[31]}}, inst[31:20]};
  assign imm_u      = {{(XLEN-32){inst[31]}}, inst[31:12], 12'b0};
  assign rs1_sext32 = {{(XLEN-32){rs1_data[31]}}, rs1_data[31:0]};
  assign rs1_zext32 = {{(XLEN-32){1'b0}}, rs1_data[31:0]};
  assign shamt6_imm = {{(XLEN-6){1'b0}}, inst[25:20]};
  assign shamt5_imm = {{(XLEN-5){1'b0}}, inst[24:20]};
  assign shamt6_reg = {{(XLEN-6){1'b0}}, rs2_data[5:0]};
  assign shamt5_reg = {{(XLEN-5){1'b0}}, rs2_data[4:0]};

  // Classify the instruction and choose the ALU op and raw operands
  always_comb begin
    legal  = 1'b0;
    alu_op = ALU_DIRECT;
    src1   = '0;
    src2   = '0;
    word   = 1'b0;
    case (opcode)
      OPC_LUI: begin
        legal  = 1'b1;
        alu_op = ALU_DIRECT;
        src2   = imm_u;
      end
      OPC_AUIPC: begin
        legal  = 1'b1;
        alu_op = ALU_ADD;
        src1   = pc;
        src2   = imm_u;
      end
      OPC_OP_IMM: begin
        legal = 1'b1;
        src1  = rs1_data;
        src2  = imm_i;
        case (funct3)
          3'b000: alu_op = ALU_ADD;
          3'b010: alu_op = ALU_SLT;
          3'b011: alu_op = ALU_SLTU;
          3'b100: alu_op = ALU_XOR;
          3'b110: alu_op = ALU_OR;
          3'b111: alu_op = ALU_AND;
          3'b001: begin
            alu_op = ALU_SLL;
            src2   = shamt6_imm;
            legal  = (inst[31:26] == 6'b000000);
          end
          default: begin
            src2 = shamt6_imm;
            if (inst[31:26] == 6'b000000) alu_op = ALU_SRL;
            else if (inst[31:26] == 6'b010000) alu_op = ALU_SRA;
            else legal = 1'b0;
          end
        endcase
      end
      OPC_OP: begin
        src1 = rs1_data;
        src2 = rs2_data;
        if (funct7 == F7_BASE) begin
          legal = 1'b1;
          case (funct3)
            3'b000: alu_op = ALU_ADD;
            3'b001: begin alu_op = ALU_SLL; src2 = shamt6_reg; end
            3'b010: alu_op = ALU_SLT;
            3'b011: alu_op = ALU_SLTU;
            3'b100: alu_op = ALU_XOR;
            3'b101: begin alu_op = ALU_SRL; src2 = shamt6_reg; end
            3'b110: alu_op = ALU_OR;
            default: alu_op = ALU_AND;
          endcase
        end else if (funct7 == F7_ALT) begin
          if (funct3 == 3'b000) begin
            legal  = 1'b1;
            alu_op = ALU_SUB;
          end else if (funct3 == 3'b101) begin
            legal  = 1'b1;
            alu_op = ALU_SRA;
            src2   = shamt6_reg;
          end
        end
      end
      OPC_OP_IMM32: begin
        word = 1'b1;
        src1 = rs1_data;
        if (funct3 == 3'b000) begin
          legal  = 1'b1;
          alu_op = ALU_ADD;
          src2   = imm_i;
        end else if (funct3 == 3'b001 && funct7 == F7_BASE) begin
          legal  = 1'b1;
          alu_op = ALU_SLL;
          src2   = shamt5_imm;
        end else if (funct3 == 3'b101 && funct7 == F7_BASE) begin
          legal  = 1'b1;
          alu_op = ALU_SRL;
          src1   = rs1_zext32;
          src2   = shamt5_imm;
        end else if (funct3 == 3'b101 && funct7 == F7_ALT) begin
          legal  = 1'b1;
          alu_op = ALU_SRA;
          src1   = rs1_sext32;
          src2   = shamt5_imm;
        end
      end
      OPC_OP32: begin
        word = 1'b1;
        src1 = rs1_data;
        src2 = rs2_data;
        if (funct7 == F7_BASE) begin
          case (funct3)
            3'b000: begin legal = 1'b1; alu_op = ALU_ADD; end
            3'b001: begin legal = 1'b1; alu_op = ALU_SLL; src2 = shamt5_reg; end
            3'b101: begin
              legal  = 1'b1;
              alu_op = ALU_SRL;
              src1   = rs1_zext32;
              src2   = shamt5_reg;
            end
            default: legal = 1'b0;
          endcase
        end else if (funct7 == F7_ALT) begin
          if (funct3 == 3'b000) begin
            legal  = 1'b1;
            alu_op = ALU_SUB;
          end else if (funct3 == 3'b101) begin
            legal  = 1'b1;
            alu_op = ALU_SRA;
            src1   = rs1_sext32;
            src2   = shamt5_reg;
          end
        end
      end
      default: legal = 1'b0;
    endcase
  end

  // Illegal encodings collapse to a harmless bundle that never writes rd
  always_comb begin
    bundle         = '0;
    bundle.alu_op  = legal ? alu_op : ALU_DIRECT;
    bundle.src1    = legal ? src1 : '0;
    bundle.src2    = legal ? src2 : '0;
    bundle.word    = legal && word;
    bundle.rd      = rd;
    bundle.rd_wen  = legal && (rd != 5'd0);
    bundle.pc      = pc;
    bundle.illegal = !legal;
  end

endmodule

// File: rtl/alu_issue.sv
// Issue stage in front of the RV64 ALU: a single valid/ready register holding the
// decoded bundle, with flush discarding the held or incoming bundle.
module alu_issue
  import alu_issue_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  alu_issue_if.slave  io
);

  issue_bundle_t dec_bundle;
  issue_bundle_t bundle_d;
  issue_bundle_t bundle_q;
  logic          valid_d;
  logic          valid_q;
  logic          in_ready;
  logic          accept;
  logic          transfer;

  alu_issue_dec u_dec (
    .inst     (io.in_inst),
    .pc       (io.in_pc),
    .rs1_data (io.in_rs1_data),
    .rs2_data (io.in_rs2_data),
    .bundle   (dec_bundle)
  );

  assign in_ready = !valid_q || io.out_ready;
  assign accept   = io.in_valid && in_ready;
  assign transfer = valid_q && io.out_ready;

  // Next register contents: flush beats accept, accept beats a plain drain
  always_comb begin
    valid_d  = valid_q;
    bundle_d = bundle_q;
    if (io.flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d  = 1'b1;
      bundle_d = dec_bundle;
    end else if (transfer) begin
      valid_d = 1'b0;
    end
  end

  // Pipeline register with synchronous active-low reset clearing everything
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q  <= 1'b0;
      bundle_q <= '0;
    end else begin
      valid_q  <= valid_d;
      bundle_q <= bundle_d;
    end
  end

  assign io.in_ready    = in_ready;
  assign io.out_valid   = valid_q;
  assign io.out_alu_op  = bundle_q.alu_op;
  assign io.out_src1    = bundle_q.src1;
  assign io.out_src2    = bundle_q.src2;
  assign io.out_word    = bundle_q.word;
  assign io.out_rd      = bundle_q.rd;
  assign io.out_rd_wen  = bundle_q.rd_wen;
  assign io.out_pc      = bundle_q.pc;
  assign io.out_illegal = bundle_q.illegal;

endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue: directed checks from known encodings plus randomized
// traffic scored against a mnemonic-level reference model through a queue.
module tb_alu_issue;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  alu_issue_if bus();

  alu_issue dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (bus)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  typedef struct packed {
    logic [3:0]  op;
    logic [63:0] src1;
    logic [63:0] src2;
    logic        word;
    logic [4:0]  rd;
    logic        rd_wen;
    logic [63:0] pc;
    logic        illegal;
  } exp_t;

  exp_t exp_q[$];

  typedef enum {
    K_ILLEGAL, K_LUI, K_AUIPC,
    K_ADDI, K_SLTI, K_SLTIU, K_XORI, K_ORI, K_ANDI, K_SLLI, K_SRLI, K_SRAI,
    K_ADD, K_SUB, K_SLL, K_SLT, K_SLTU, K_XOR, K_SRL, K_SRA, K_OR, K_AND,
    K_ADDIW, K_SLLIW, K_SRLIW, K_SRAIW,
    K_ADDW, K_SUBW, K_SLLW, K_SRLW, K_SRAW
  } kind_e;

  // Name the instruction from its {funct7, funct3, opcode} fields
  function automatic kind_e classify(input logic [31:0] inst);
    casez ({inst[31:25], inst[14:12], inst[6:0]})
      17'b???????_???_0110111: return K_LUI;
      17'b???????_???_0010111: return K_AUIPC;
      17'b???????_000_0010011: return K_ADDI;
      17'b???????_010_0010011: return K_SLTI;
      17'b???????_011_0010011: return K_SLTIU;
      17'b???????_100_0010011: return K_XORI;
      17'b???????_110_0010011: return K_ORI;
      17'b???????_111_0010011: return K_ANDI;
      17'b000000?_001_0010011: return K_SLLI;
      17'b000000?_101_0010011: return K_SRLI;
      17'b010000?_101_0010011: return K_SRAI;
      17'b0000000_000_0110011: return K_ADD;
      17'b0100000_000_0110011: return K_SUB;
      17'b0000000_001_0110011: return K_SLL;
      17'b0000000_010_0110011: return K_SLT;
      17'b0000000_011_0110011: return K_SLTU;
      17'b0000000_100_0110011: return K_XOR;
      17'b0000000_101_0110011: return K_SRL;
      17'b0100000_101_0110011: return K_SRA;
      17'b0000000_110_0110011: return K_OR;
      17'b0000000_111_0110011: return K_AND;
      17'b???????_000_0011011: return K_ADDIW;
      17'b0000000_001_0011011: return K_SLLIW;
      17'b0000000_101_0011011: return K_SRLIW;
      17'b0100000_101_0011011: return K_SRAIW;
      17'b0000000_000_0111011: return K_ADDW;
      17'b0100000_000_0111011: return K_SUBW;
      17'b0000000_001_0111011: return K_SLLW;
      17'b0000000_101_0111011: return K_SRLW;
      17'b0100000_101_0111011: return K_SRAW;
      default:                 return K_ILLEGAL;
    endcase
  endfunction

  // Expected bundle for one instruction, computed from the mnemonic's meaning
  function automatic exp_t model(input logic [31:0] inst, input logic [63:0] pc,
                                 input logic [63:0] rs1, input logic [63:0] rs2);
    exp_t e;
    logic [63:0] imm_i, imm_u, sx, zx, sh6i, sh5i;
    imm_i = {{52{inst[31]}}, inst[31:20]};
    imm_u = {{32{inst[31]}}, inst[31:12], 12'h000};
    sx    = {{32{rs1[31]}}, rs1[31:0]};
    zx    = {32'h0, rs1[31:0]};
    sh6i  = {58'h0, inst[25:20]};
    sh5i  = {59'h0, inst[24:20]};
    e     = '0;
    e.rd  = inst[11:7];
    e.pc  = pc;
    case (classify(inst))
      K_LUI:   begin e.op = 4'd0;  e.src2 = imm_u; end
      K_AUIPC: begin e.op = 4'd1;  e.src1 = pc;  e.src2 = imm_u; end
      K_ADDI:  begin e.op = 4'd1;  e.src1 = rs1; e.src2 = imm_i; end
      K_SLTI:  begin e.op = 4'd9;  e.src1 = rs1; e.src2 = imm_i; end
      K_SLTIU: begin e.op = 4'd10; e.src1 = rs1; e.src2 = imm_i; end
      K_XORI:  begin e.op = 4'd5;  e.src1 = rs1; e.src2 = imm_i; end
      K_ORI:   begin e.op = 4'd4;  e.src1 = rs1; e.src2 = imm_i; end
      K_ANDI:  begin e.op = 4'd3;  e.src1 = rs1; e.src2 = imm_i; end
      K_SLLI:  begin e.op = 4'd6;  e.src1 = rs1; e.src2 = sh6i; end
      K_SRLI:  begin e.op = 4'd7;  e.src1 = rs1; e.src2 = sh6i; end
      K_SRAI:  begin e.op = 4'd8;  e.src1 = rs1; e.src2 = sh6i; end
      K_ADD:   begin e.op = 4'd1;  e.src1 = rs1; e.src2 = rs2; end
      K_SUB:   begin e.op = 4'd2;  e.src1 = rs1; e.src2 = rs2; end
      K_SLL:   begin e.op = 4'd6;  e.src1 = rs1; e.src2 = rs2 % 64; end
      K_SLT:   begin e.op = 4'd9;  e.src1 = rs1; e.src2 = rs2; end
      K_SLTU:  begin e.op = 4'd10; e.src1 = rs1; e.src2 = rs2; end
      K_XOR:   begin e.op = 4'd5;  e.src1 = rs1; e.src2 = rs2; end
      K_SRL:   begin e.op = 4'd7;  e.src1 = rs1; e.src2 = rs2 % 64; end
      K_SRA:   begin e.op = 4'd8;  e.src1 = rs1; e.src2 = rs2 % 64; end
      K_OR:    begin e.op = 4'd4;  e.src1 = rs1; e.src2 = rs2; end
      K_AND:   begin e.op = 4'd3;  e.src1 = rs1; e.src2 = rs2; end
      K_ADDIW: begin e.op = 4'd1;  e.src1 = rs1; e.src2 = imm_i;    e.word = 1'b1; end
      K_SLLIW: begin e.op = 4'd6;  e.src1 = rs1; e.src2 = sh5i;     e.word = 1'b1; end
      K_SRLIW: begin e.op = 4'd7;  e.src1 = zx;  e.src2 = sh5i;     e.word = 1'b1; end
      K_SRAIW: begin e.op = 4'd8;  e.src1 = sx;  e.src2 = sh5i;     e.word = 1'b1; end
      K_ADDW:  begin e.op = 4'd1;  e.src1 = rs1; e.src2 = rs2;      e.word = 1'b1; end
      K_SUBW:  begin e.op = 4'd2;  e.src1 = rs1; e.src2 = rs2;      e.word = 1'b1; end
      K_SLLW:  begin e.op = 4'd6;  e.src1 = rs1; e.src2 = rs2 % 32; e.word = 1'b1; end
      K_SRLW:  begin e.op = 4'd7;  e.src1 = zx;  e.src2 = rs2 % 32; e.word = 1'b1; end
      K_SRAW:  begin e.op = 4'd8;  e.src1 = sx;  e.src2 = rs2 % 32; e.word = 1'b1; end
      default: e.illegal = 1'b1;
    endcase
    e.rd_wen = !e.illegal && (e.rd != 5'd0);
    return e;
  endfunction

  // Random instruction biased toward the supported opcodes and funct7 values
  function automatic logic [31:0] rand_inst();
    logic [31:0] r, r2;
    logic [6:0]  opc, f7;
    r  = $urandom;
    r2 = $urandom;
    case ($urandom_range(0, 6))
      0: opc = 7'b0110111;
      1: opc = 7'b0010111;
      2: opc = 7'b0010011;
      3: opc = 7'b0110011;
      4: opc = 7'b0011011;
      5: opc = 7'b0111011;
      default: opc = r2[6:0];
    endcase
    case ($urandom_range(0, 4))
      0: f7 = 7'h00;
      1: f7 = 7'h20;
      2: f7 = 7'h01;
      3: f7 = 7'h21;
      default: f7 = r2[13:7];
    endcase
    r[31:25] = f7;
    r[6:0]   = opc;
    if ($urandom_range(0, 7) == 0) r[11:7] = 5'd0;
    return r;
  endfunction

  function automatic logic [63:0] rand64();
    if ($urandom_range(0, 3) == 0) return 64'($urandom_range(0, 70));
    return {$urandom, $urandom};
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic checkBundle(input string tag, input logic v, input logic [3:0] op,
                             input logic [63:0] s1, input logic [63:0] s2, input logic w,
                             input logic [4:0] rd, input logic wen, input logic ill,
                             input logic [63:0] pc);
    checkOutput({tag, "_valid"},   64'(bus.out_valid),   64'(v));
    checkOutput({tag, "_op"},      64'(bus.out_alu_op),  64'(op));
    checkOutput({tag, "_src1"},    bus.out_src1,         s1);
    checkOutput({tag, "_src2"},    bus.out_src2,         s2);
    checkOutput({tag, "_word"},    64'(bus.out_word),    64'(w));
    checkOutput({tag, "_rd"},      64'(bus.out_rd),      64'(rd));
    checkOutput({tag, "_rd_wen"},  64'(bus.out_rd_wen),  64'(wen));
    checkOutput({tag, "_illegal"}, 64'(bus.out_illegal), 64'(ill));
    checkOutput({tag, "_pc"},      bus.out_pc,           pc);
  endtask

  // Called 1 time unit after a rising edge; drives one cycle and returns 1 unit
  // after the next rising edge. Just before that edge the expected bundle is queued.
  task automatic applyStimulus(input logic [31:0] inst, input logic [63:0] pc,
                               input logic [63:0] rs1, input logic [63:0] rs2,
                               input logic v, input logic rdy, input logic fl,
                               input logic rstn);
    rst_n           = rstn;
    bus.in_inst     = inst;
    bus.in_pc       = pc;
    bus.in_rs1_data = rs1;
    bus.in_rs2_data = rs2;
    bus.in_valid    = v;
    bus.out_ready   = rdy;
    bus.flush       = fl;
    #7;
    if (!rstn) exp_q.delete();
    else if (v && bus.in_ready && !fl) exp_q.push_back(model(inst, pc, rs1, rs2));
    @(posedge clk);
    #1;
  endtask

  // Monitor: at each falling edge, check handshake state and score transfers
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        checkOutput("mon_out_valid", 64'(bus.out_valid), 64'(exp_q.size() != 0));
        checkOutput("mon_in_ready", 64'(bus.in_ready),
                    64'((exp_q.size() == 0) || bus.out_ready));
        if (bus.out_valid && exp_q.size() != 0) begin
          if (bus.out_ready) begin
            e = exp_q.pop_front();
            checkOutput("mon_op",      64'(bus.out_alu_op),  64'(e.op));
            checkOutput("mon_src1",    bus.out_src1,         e.src1);
            checkOutput("mon_src2",    bus.out_src2,         e.src2);
            checkOutput("mon_word",    64'(bus.out_word),    64'(e.word));
            checkOutput("mon_rd",      64'(bus.out_rd),      64'(e.rd));
            checkOutput("mon_rd_wen",  64'(bus.out_rd_wen),  64'(e.rd_wen));
            checkOutput("mon_pc",      bus.out_pc,           e.pc);
            checkOutput("mon_illegal", 64'(bus.out_illegal), 64'(e.illegal));
          end else if (bus.flush) begin
            void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  localparam logic [31:0] I_ADDI  = 32'hFFF00093;
  localparam logic [31:0] I_SRAW  = 32'h4020D1BB;
  localparam logic [31:0] I_SRL   = {7'b0000000, 5'd2, 5'd1, 3'b101, 5'd3, 7'b0110011};
  localparam logic [31:0] I_SLLIW = {7'b0000001, 5'd1, 5'd1, 3'b001, 5'd3, 7'b0011011};
  localparam logic [31:0] I_LUI   = {20'h12345, 5'd5, 7'b0110111};

  // Directed scenarios followed by randomized traffic and a final drain
  initial begin
    bus.in_valid    = 1'b0;
    bus.in_inst     = '0;
    bus.in_pc       = '0;
    bus.in_rs1_data = '0;
    bus.in_rs2_data = '0;
    bus.flush       = 1'b0;
    bus.out_ready   = 1'b0;
    @(posedge clk);
    #1;
    applyStimulus(32'h0, 64'h0, 64'h0, 64'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(32'h0, 64'h0, 64'h0, 64'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkBundle("reset", 1'b0, 4'd0, 64'h0, 64'h0, 1'b0, 5'd0, 1'b0, 1'b0, 64'h0);
    checkOutput("reset_in_ready", 64'(bus.in_ready), 64'h1);

    applyStimulus(I_ADDI, 64'h1000, 64'h0, 64'h0, 1'b1, 1'b0, 1'b0, 1'b1);
    checkBundle("addi", 1'b1, 4'd1, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 5'd1, 1'b1,
                1'b0, 64'h1000);

    for (int i = 0; i < 3; i++) begin
      applyStimulus(I_SRAW, 64'h1004, 64'h1234_5678_8000_0000, 64'd33,
                    1'b1, 1'b0, 1'b0, 1'b1);
      checkOutput("stall_in_ready", 64'(bus.in_ready), 64'h0);
      checkBundle("stall_hold", 1'b1, 4'd1, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 5'd1,
                  1'b1, 1'b0, 64'h1000);
    end

    applyStimulus(I_SRAW, 64'h1004, 64'h1234_5678_8000_0000, 64'd33, 1'b1, 1'b1, 1'b0, 1'b1);
    checkBundle("sraw", 1'b1, 4'd8, 64'hFFFF_FFFF_8000_0000, 64'h1, 1'b1, 5'd3, 1'b1,
                1'b0, 64'h1004);

    applyStimulus(I_SRL, 64'h1008, 64'hF000_0000_0000_0001, 64'h1_0000_0043,
                  1'b1, 1'b1, 1'b0, 1'b1);
    checkBundle("srl", 1'b1, 4'd7, 64'hF000_0000_0000_0001, 64'h3, 1'b0, 5'd3, 1'b1,
                1'b0, 64'h1008);

    applyStimulus(I_SLLIW, 64'h100C, 64'hDEAD, 64'h7, 1'b1, 1'b1, 1'b0, 1'b1);
    checkBundle("slliw_bad", 1'b1, 4'd0, 64'h0, 64'h0, 1'b0, 5'd3, 1'b0, 1'b1, 64'h100C);

    applyStimulus(I_LUI, 64'h1010, 64'h0, 64'h0, 1'b1, 1'b1, 1'b1, 1'b1);
    checkOutput("flush_valid", 64'(bus.out_valid), 64'h0);

    applyStimulus(I_LUI, 64'h1014, 64'h55, 64'h66, 1'b1, 1'b0, 1'b0, 1'b1);
    checkBundle("lui", 1'b1, 4'd0, 64'h0, 64'h0000_0000_1234_5000, 1'b0, 5'd5, 1'b1,
                1'b0, 64'h1014);

    applyStimulus(I_ADDI, 64'h1018, 64'h0, 64'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    checkBundle("rst_stall", 1'b0, 4'd0, 64'h0, 64'h0, 1'b0, 5'd0, 1'b0, 1'b0, 64'h0);
    checkOutput("rst_in_ready", 64'(bus.in_ready), 64'h1);

    for (int i = 0; i < 600; i++) begin
      applyStimulus(rand_inst(), {$urandom, $urandom}, rand64(), rand64(),
                    ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0),
                    ($urandom_range(0, 19) == 0), 1'b1);
    end

    for (int i = 0; i < 4; i++) begin
      applyStimulus(32'h0, 64'h0, 64'h0, 64'h0, 1'b0, 1'b1, 1'b0, 1'b1);
    end
    checkOutput("drain_queue_empty", 64'(exp_q.size()), 64'h0);
    checkOutput("drain_valid", 64'(bus.out_valid), 64'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/alu_issue.md
Name: alu_issue

Overview:
- Issue stage that produces operand/op bundles for the RV64 integer ALU (4-bit op encoding below).
- Decodes one RV64I integer-compute instruction per transfer.
- Selects and conditions the two operands: immediates, PC, shift-amount masking, W-variant extension.
- Holds the bundle in a single valid/ready pipeline register in front of the ALU; upstream is the register-read stage, downstream is the ALU plus the writeback tag path.

Parameters:
XLEN, 64, datapath width; only 64 is supported.

Ports:
clk  in  1  clock
rst_n  in  1  synchronous reset, active-low
in_valid  in  1  upstream bundle valid
in_ready  out  1  stage can accept this cycle
in_inst  in  32  instruction word
in_pc  in  64  instruction PC
in_rs1_data  in  64  rs1 register value
in_rs2_data  in  64  rs2 register value
flush  in  1  discard held bundle (redirect)
out_valid  out  1  bundle valid toward ALU
out_ready  in  1  ALU/execute accepts bundle
out_alu_op  out  4  ALU op
out_src1  out  64  ALU operand 1
out_src2  out  64  ALU operand 2
out_word  out  1  consumer sign-extends result[31:0] to 64
out_rd  out  5  destination register
out_rd_wen  out  1  write rd
out_pc  out  64  PC of held instruction
out_illegal  out  1  not a supported encoding

Behaviour:
- ALU op encoding: 0000 direct(src2), 0001 add, 0010 sub, 0011 and, 0100 or, 0101 xor, 0110 sll, 0111 srl, 1000 sra, 1001 slt, 1010 sltu. The ALU shifts by the full src2, so this stage masks shift amounts.
- Reset (rst_n=0 at posedge): out_valid=0 and every other output register=0. Reset wins over flush and accept, including mid-transfer.
- in_ready = !out_valid || out_ready (combinational; no dependence on in_valid).
- Accept when in_valid && in_ready. The decoded bundle is registered at that edge, so latency is 1 cycle.
- Transfer out when out_valid && out_ready.
- Accept and transfer-out in the same cycle: the new bundle replaces the old one and out_valid stays 1.
- Hold while out_valid && !out_ready: all outputs stable.
- flush=1: out_valid=0 next cycle, and any same-cycle accept is dropped. flush has priority over accept.
- Immediates:
  - imm_i = sext(inst[31:20])
  - imm_u = sext({inst[31:12], 12'b0})
- Decode by opcode:
  - LUI 0110111: op direct, src1=0, src2=imm_u.
  - AUIPC 0010111: add, src1=pc, src2=imm_u.
  - OP-IMM 0010011, src1=rs1, src2=imm_i: funct3 000 add, 010 slt, 011 sltu, 100 xor, 110 or, 111 and.
  - OP-IMM shifts: 001 sll requires inst[31:26]=0. 101 is srl if inst[31:26]=000000, sra if 010000. For shifts, src2={58'b0, inst[25:20]}.
  - OP 0110011 with funct7 0000000: add, sll, slt, sltu, xor, srl, or, and by funct3.
  - OP with funct7 0100000: funct3 000 sub, 101 sra.
  - OP shifts: src2=rs2 & 63.
  - OP-IMM-32 0011011 and OP-32 0111011 set out_word=1:
    - addiw: add; addw: add; subw: sub.
    - slliw/sllw: sll, src1=rs1.
    - srliw/srlw: srl, src1=zext(rs1[31:0]).
    - sraiw/sraw: sra, src1=sext(rs1[31:0]).
    - W shift amount = 5 bits (imm inst[24:20] with inst[25]=0 required, or rs2 & 31).
- Illegal (any other opcode/funct combination, including funct7 0000001 M-ext): out_illegal=1, op 0000, src1=src2=0, out_rd_wen=0, out_word=0. Still transferred normally.
- out_rd=inst[11:7]; out_rd_wen = legal && rd!=0.
- out_pc=in_pc for every bundle.

Decomposition:
- Shared package (e.g. npc_pkg): ALU op localparams (ALU_DIRECT..ALU_SLTU), opcode constants (OPC_LUI, OPC_AUIPC, OPC_OP_IMM, OPC_OP, OPC_OP_IMM32, OPC_OP32), funct7 constants. The ALU must use the same op constants.
- One sub-module: alu_issue_dec, purely combinational. It takes inst/pc/rs1/rs2 and produces the next bundle.
- The top contains only the handshake register and flush/reset control.

Test Plan:
- addi x1,x0,-1 (0xFFF00093), rs1=0 -> next cycle out_valid=1, op 0001, src1=0, src2=0xFFFF_FFFF_FFFF_FFFF, rd=1, rd_wen=1, word=0.
- sraw x3,x1,x2 (0x4020D1BB), rs1=0x1234_5678_8000_0000, rs2=33 -> op 1000, src1=0xFFFF_FFFF_8000_0000, src2=1, word=1.
- srl x3,x1,x2 with rs2=0x1_0000_0043 -> src2=3. slliw with inst[25]=1 -> illegal=1, rd_wen=0.
- Backpressure: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, outputs unchanged. Raise out_ready with a new instruction pending -> back-to-back transfer, no bubble, no duplicate.
- flush in the same cycle as an accept of lui x5,0x12345 -> out_valid=0 next cycle. Next accept proceeds normally (src2=0x0000_0000_1234_5000).
- rst_n=0 while holding a stalled bundle -> out_valid=0, all outputs 0 after that edge, in_ready=1.
